clk_sel_ctrl: RTL and testbench

//  Sequencer that drives the 2-bit select of the glitch-free 4:1 clock mux tree.
//  - Accepts clock-switch requests over a valid/ready handshake.
//  - Waits for the target source to report lock, then drives the new select.
//  - Holds off further requests until the mux tree has settled.
//  - Runs on the always-on reference clock, which is source 0 of the mux.

---
 rtl/clk_sel_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_clk_sel_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_sel_ctrl.sv
// -----------------------------------------------------------------------------
// clk_sel_ctrl
//   Sequencer for the 2-bit select of a glitch-free 4:1 clock mux tree. It
//   runs on the always-on reference clock, which is mux source 0.
//   A request is accepted over a valid/ready handshake. The sequencer waits
//   for the target source to report lock, then drives the new select. It
//   accepts no further requests until the mux tree has settled.
//
//   Optional feature: define CLK_SEL_FAILSAFE_EN to enable failsafe fallback.
//   If the active non-reference source loses lock while IDLE or SETTLE, the
//   select falls back to source 0 and a settle period starts. This settle
//   produces no done_o.
//
// Ports
//   clk_i        in   always-on reference clock (mux source 0)
//   arst_i       in   asynchronous reset, active-high
//   req_valid_i  in   switch request valid
//   req_sel_i    in   [1:0] requested source index
//   req_ready_o  out  high only in IDLE (and no failsafe trip this cycle)
//   lock_i       in   [3:0] per-source lock, asynchronous; bit 0 ignored
//   sel_o        out  [1:0] registered select to the mux tree
//   busy_o       out  high in any state other than IDLE
//   done_o       out  1-cycle pulse: request completed
//   err_o        out  1-cycle pulse: lock timeout, request dropped
//   fail_o       out  1-cycle pulse: failsafe fallback taken
// -----------------------------------------------------------------------------
module clk_sel_ctrl #(
    parameter int SETTLE_CYCLES = 16,
    parameter int LOCK_TIMEOUT  = 255,
    parameter int RESET_SEL     = 0
) (
    input  logic       clk_i,
    input  logic       arst_i,
    input  logic       req_valid_i,
    input  logic [1:0] req_sel_i,
    output logic       req_ready_o,
    input  logic [3:0] lock_i,
    output logic [1:0] sel_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o,
    output logic       fail_o
);

    // One counter is shared between the timeout and settle phases; they are
    // never active together. It only needs to reach (max - 1).
    localparam int CNT_MAX = (SETTLE_CYCLES > LOCK_TIMEOUT) ? SETTLE_CYCLES : LOCK_TIMEOUT;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [1:0]       SEL_RST     = 2'(RESET_SEL);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_LOCK = 2'd1,
        SWITCH    = 2'd2,
        SETTLE    = 2'd3
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [1:0]       sel_reg, sel_next;
    logic [1:0]       tgt_reg, tgt_next;
    logic             done_reg, done_next;
    logic             err_reg, err_next;
    logic             fail_reg, fail_next;
    logic             fs_settle_reg, fs_settle_next;   // current settle came from failsafe
    logic [3:0]       lock_s;
    logic             fs_trip;
    logic             transfer;
    logic             unused_lock0;

    // The reference source is always running, so its lock input is not used.
    assign unused_lock0 = lock_i[0];
    assign lock_s[0]    = 1'b1;

    // Two-flop synchronizers for the lock inputs of sources 1..3.
    genvar gi;
    generate
        for (gi = 1; gi < 4; gi++) begin : g_sync
            logic s1_reg, s2_reg;
            always_ff @(posedge clk_i or posedge arst_i) begin
                if (arst_i) begin
                    s1_reg <= 1'b0;
                    s2_reg <= 1'b0;
                end else begin
                    s1_reg <= lock_i[gi];
                    s2_reg <= s1_reg;
                end
            end
            assign lock_s[gi] = s2_reg;
        end
    endgenerate

`ifdef CLK_SEL_FAILSAFE_EN
    // Lost lock on the active non-reference source. Gate with reset so the
    // handshake reads ready while reset is held.
    assign fs_trip = ~arst_i & ((state_reg == IDLE) || (state_reg == SETTLE)) &
                     (sel_reg != 2'd0) & ~lock_s[sel_reg];
`else
    assign fs_trip = 1'b0;
`endif

    assign req_ready_o = (state_reg == IDLE) & ~fs_trip;
    assign transfer    = req_valid_i & req_ready_o;
    assign busy_o      = (state_reg != IDLE);
    assign sel_o       = sel_reg;
    assign done_o      = done_reg;
    assign err_o       = err_reg;
    assign fail_o      = fail_reg;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            sel_reg       <= SEL_RST;
            tgt_reg       <= SEL_RST;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            fail_reg      <= 1'b0;
            fs_settle_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            sel_reg       <= sel_next;
            tgt_reg       <= tgt_next;
            done_reg      <= done_next;
            err_reg       <= err_next;
            fail_reg      <= fail_next;
            fs_settle_reg <= fs_settle_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        sel_next       = sel_reg;
        tgt_next       = tgt_reg;
        done_next      = 1'b0;
        err_next       = 1'b0;
        fail_next      = 1'b0;
        fs_settle_next = fs_settle_reg;

        case (state_reg)
            IDLE: begin
                if (fs_trip) begin
                    sel_next       = 2'd0;
                    fail_next      = 1'b1;
                    cnt_next       = '0;
                    fs_settle_next = 1'b1;
                    state_next     = SETTLE;
                end else if (transfer) begin
                    tgt_next = req_sel_i;
                    if (req_sel_i == sel_reg) begin
                        // Already on the requested source: complete at once.
                        done_next = 1'b1;
                    end else begin
                        cnt_next   = '0;
                        state_next = WAIT_LOCK;
                    end
                end
            end
            WAIT_LOCK: begin
                if (lock_s[tgt_reg]) begin
                    state_next = SWITCH;
                end else if (cnt_reg == TO_LAST) begin
                    err_next   = 1'b1;
                    state_next = IDLE;
                end else if (cnt_reg != '1) begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            SWITCH: begin
                sel_next       = tgt_reg;
                cnt_next       = '0;
                fs_settle_next = 1'b0;
                state_next     = SETTLE;
            end
            SETTLE: begin
                if (fs_trip) begin
                    sel_next       = 2'd0;
                    fail_next      = 1'b1;
                    cnt_next       = '0;
                    fs_settle_next = 1'b1;
                end else if (cnt_reg == SETTLE_LAST) begin
                    done_next      = ~fs_settle_reg;
                    fs_settle_next = 1'b0;
                    state_next     = IDLE;
                end else if (cnt_reg != '1) begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_clk_sel_ctrl.sv
module tb_clk_sel_ctrl;

    logic       clk = 1'b0;
    logic       arst_i;
    logic       req_valid_i;
    logic [1:0] req_sel_i;
    logic       req_ready_o;
    logic [3:0] lock_i;
    logic [1:0] sel_o;
    logic       busy_o;
    logic       done_o;
    logic       err_o;
    logic       fail_o;

    int tests    = 0;
    int failures = 0;
    int excl_bad = 0;

    clk_sel_ctrl #(
        .SETTLE_CYCLES(4),
        .LOCK_TIMEOUT (8),
        .RESET_SEL    (0)
    ) dut (
        .clk_i      (clk),
        .arst_i     (arst_i),
        .req_valid_i(req_valid_i),
        .req_sel_i  (req_sel_i),
        .req_ready_o(req_ready_o),
        .lock_i     (lock_i),
        .sel_o      (sel_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .fail_o     (fail_o)
    );

    always #5 clk = ~clk;

    // Pulses must never coincide.
    always @(negedge clk) begin
        if ($countones({done_o, err_o, fail_o}) > 1) excl_bad++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset with the given lock inputs, release mid-cycle, then let the
    // synchronizers fill.
    task automatic do_reset(input logic [3:0] lk);
        req_valid_i = 1'b0;
        req_sel_i   = 2'd0;
        lock_i      = lk;
        arst_i      = 1'b1;
        tick();
        tick();
        #2 arst_i = 1'b0;
        tick();
        tick();
        tick();
    endtask

    // Drive one request from IDLE; returns after the accept edge.
    task automatic accept(input logic [1:0] s);
        req_valid_i = 1'b1;
        req_sel_i   = s;
        tick();
        req_valid_i = 1'b0;
    endtask

    // Ticks until done_o or err_o is seen; n = -1 if the bound expires.
    task automatic wait_end(input int maxc, output int n);
        n = -1;
        for (int k = 1; k <= maxc; k++) begin
            tick();
            if (done_o || err_o) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        req_valid_i = 1'b0;
        req_sel_i   = 2'd0;
        lock_i      = 4'b1111;
        arst_i      = 1'b1;
        tick();
        tests++; if (req_ready_o !== 1'b1) begin failures++; $display("FAIL rst_ready: got %b expected 1", req_ready_o); end
        tests++; if (busy_o !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b expected 0", busy_o); end
        tests++; if (sel_o !== 2'd0) begin failures++; $display("FAIL rst_sel: got %0d expected 0", sel_o); end
        tests++; if ({done_o, err_o, fail_o} !== 3'b000) begin failures++; $display("FAIL rst_pulses: got %b expected 000", {done_o, err_o, fail_o}); end
        $display("[TB] reset: ready=%b busy=%b sel=%0d", req_ready_o, busy_o, sel_o);
    endtask

    // Request issued at the very first edge after reset release.
    task automatic test_switch_after_reset();
        int done_k = -1;
        int dcount = 0;
        logic [1:0] s2 = 2'd3;
        logic [1:0] s3 = 2'd3;
        arst_i      = 1'b1;
        lock_i      = 4'b0010;
        req_valid_i = 1'b1;
        req_sel_i   = 2'd1;
        tick();
        tick();
        #2 arst_i = 1'b0;
        tick();
        req_valid_i = 1'b0;
        tests++; if (busy_o !== 1'b1) begin failures++; $display("FAIL t1_busy: got %b expected 1", busy_o); end
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 2) s2 = sel_o;
            if (k == 3) s3 = sel_o;
            if (done_o) begin
                dcount++;
                if (done_k < 0) done_k = k;
            end
        end
        tests++; if (s2 !== 2'd0) begin failures++; $display("FAIL t1_sel_before_switch: got %0d expected 0", s2); end
        tests++; if (s3 !== 2'd1) begin failures++; $display("FAIL t1_sel_after_switch: got %0d expected 1", s3); end
        tests++; if (done_k != 7) begin failures++; $display("FAIL t1_done_latency: got %0d expected 7", done_k); end
        tests++; if (dcount != 1) begin failures++; $display("FAIL t1_done_count: got %0d expected 1", dcount); end
        $display("[TB] switch to 1: done after %0d cycles, sel=%0d", done_k, sel_o);
    endtask

    task automatic test_timeout();
        int err_k = -1;
        int dcount = 0;
        logic [1:0] sel_at_err = 2'd3;
        logic rdy_at_err = 1'b0;
        logic rdy_next = 1'b0;
        do_reset(4'b0001);
        accept(2'd2);
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (done_o) dcount++;
            if (err_k >= 0 && k == err_k + 1) rdy_next = req_ready_o;
            if (err_o && err_k < 0) begin
                err_k      = k;
                sel_at_err = sel_o;
                rdy_at_err = req_ready_o;
            end
        end
        tests++; if (err_k != 8) begin failures++; $display("FAIL t2_err_latency: got %0d expected 8", err_k); end
        tests++; if (sel_at_err !== 2'd0) begin failures++; $display("FAIL t2_sel: got %0d expected 0", sel_at_err); end
        tests++; if (rdy_at_err !== 1'b1 || rdy_next !== 1'b1) begin failures++; $display("FAIL t2_ready: got %b%b expected 11", rdy_at_err, rdy_next); end
        tests++; if (dcount != 0) begin failures++; $display("FAIL t2_no_done: got %0d expected 0", dcount); end
        $display("[TB] timeout to 2: err after %0d cycles, sel=%0d", err_k, sel_at_err);
    endtask

    task automatic test_same_sel();
        int n;
        do_reset(4'b0010);
        accept(2'd1);
        wait_end(20, n);
        tests++; if (n != 6) begin failures++; $display("FAIL t3_setup_latency: got %0d expected 6", n); end
        tick();
        accept(2'd1);
        tests++; if (done_o !== 1'b1) begin failures++; $display("FAIL t3_done_next: got %b expected 1", done_o); end
        tests++; if (busy_o !== 1'b0) begin failures++; $display("FAIL t3_busy0: got %b expected 0", busy_o); end
        tick();
        tests++; if (done_o !== 1'b0) begin failures++; $display("FAIL t3_done_once: got %b expected 0", done_o); end
        tests++; if (busy_o !== 1'b0 || sel_o !== 2'd1) begin failures++; $display("FAIL t3_hold: got busy=%b sel=%0d expected busy=0 sel=1", busy_o, sel_o); end
        $display("[TB] same-select request: sel=%0d busy=%b", sel_o, busy_o);
    endtask

    task automatic test_back_to_back();
        int done_k = -1;
        int n;
        int rdy_high_busy = 0;
        do_reset(4'b1100);
        req_valid_i = 1'b1;
        req_sel_i   = 2'd3;
        tick();
        req_sel_i = 2'd2;          // valid stays high with a new target
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (done_o) begin
                done_k = k;
                break;
            end
            if (req_ready_o) rdy_high_busy++;
        end
        tests++; if (done_k != 6) begin failures++; $display("FAIL t4_first_latency: got %0d expected 6", done_k); end
        tests++; if (rdy_high_busy != 0) begin failures++; $display("FAIL t4_ready_while_busy: got %0d expected 0", rdy_high_busy); end
        tests++; if (sel_o !== 2'd3) begin failures++; $display("FAIL t4_first_sel: got %0d expected 3", sel_o); end
        tick();                    // second request accepted here
        req_valid_i = 1'b0;
        tests++; if (busy_o !== 1'b1) begin failures++; $display("FAIL t4_second_accept: got %b expected 1", busy_o); end
        wait_end(20, n);
        tests++; if (n != 6) begin failures++; $display("FAIL t4_second_latency: got %0d expected 6", n); end
        tests++; if (sel_o !== 2'd2) begin failures++; $display("FAIL t4_final_sel: got %0d expected 2", sel_o); end
        $display("[TB] back-to-back 3 then 2: final sel=%0d", sel_o);
    endtask

    task automatic test_reset_mid_settle();
        int dcount = 0;
        int n;
        do_reset(4'b1000);
        accept(2'd3);
        tick();
        tick();
        tick();
        tests++; if (sel_o !== 2'd3 || busy_o !== 1'b1) begin failures++; $display("FAIL t5_in_settle: got sel=%0d busy=%b expected sel=3 busy=1", sel_o, busy_o); end
        #2 arst_i = 1'b1;
        #1;
        tests++; if (sel_o !== 2'd0) begin failures++; $display("FAIL t5_async_sel: got %0d expected 0", sel_o); end
        tests++; if (busy_o !== 1'b0 || req_ready_o !== 1'b1) begin failures++; $display("FAIL t5_async_idle: got busy=%b ready=%b expected busy=0 ready=1", busy_o, req_ready_o); end
        #2 arst_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (done_o) dcount++;
        end
        tests++; if (dcount != 0) begin failures++; $display("FAIL t5_no_done: got %0d expected 0", dcount); end
        accept(2'd3);
        wait_end(20, n);
        tests++; if (n != 6 || sel_o !== 2'd3) begin failures++; $display("FAIL t5_post_reset: got lat=%0d sel=%0d expected lat=6 sel=3", n, sel_o); end
        $display("[TB] reset during settle: post-reset latency %0d sel=%0d", n, sel_o);
    endtask

    task automatic test_failsafe();
        int n;
        int fail_k = -1;
        int busy_cnt = 0;
        int dcount = 0;
        logic [1:0] sel_k3 = 2'd3;
        do_reset(4'b0100);
        accept(2'd2);
        wait_end(20, n);
        tests++; if (n != 6 || sel_o !== 2'd2) begin failures++; $display("FAIL t6_setup: got lat=%0d sel=%0d expected lat=6 sel=2", n, sel_o); end
        lock_i = 4'b0000;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (fail_o && fail_k < 0) fail_k = k;
            if (busy_o) busy_cnt++;
            if (done_o) dcount++;
            if (k == 3) sel_k3 = sel_o;
        end
`ifdef CLK_SEL_FAILSAFE_EN
        tests++; if (fail_k != 3) begin failures++; $display("FAIL t6_fail_latency: got %0d expected 3", fail_k); end
        tests++; if (sel_k3 !== 2'd0 || sel_o !== 2'd0) begin failures++; $display("FAIL t6_fallback_sel: got %0d/%0d expected 0/0", sel_k3, sel_o); end
        tests++; if (busy_cnt != 4) begin failures++; $display("FAIL t6_busy_cycles: got %0d expected 4", busy_cnt); end
`else
        tests++; if (fail_k != -1) begin failures++; $display("FAIL t6_fail_tied: got %0d expected -1", fail_k); end
        tests++; if (sel_k3 !== 2'd2 || sel_o !== 2'd2) begin failures++; $display("FAIL t6_sel_kept: got %0d/%0d expected 2/2", sel_k3, sel_o); end
        tests++; if (busy_cnt != 0) begin failures++; $display("FAIL t6_busy_cycles: got %0d expected 0", busy_cnt); end
`endif
        tests++; if (dcount != 0) begin failures++; $display("FAIL t6_no_done: got %0d expected 0", dcount); end
        $display("[TB] lock loss on source 2: fail at %0d, sel=%0d, busy cycles %0d", fail_k, sel_o, busy_cnt);
    endtask

    initial begin
        arst_i      = 1'b1;
        req_valid_i = 1'b0;
        req_sel_i   = 2'd0;
        lock_i      = 4'b0000;
        test_reset();
        test_switch_after_reset();
        test_timeout();
        test_same_sel();
        test_back_to_back();
        test_reset_mid_settle();
        test_failsafe();
        tests++; if (excl_bad != 0) begin failures++; $display("FAIL pulse_exclusive: got %0d overlapping cycles expected 0", excl_bad); end
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
